seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring (shift-subtract) unsigned integer divider; the inverse operation of the team's combinational multiplier blocks.
- Produces quotient and remainder of dividend / divisor, one quotient bit per clock.
- Uses a start/busy/done handshake.
- Sits between switch-input registers and LED/7-seg display logic in board-level tops; reusable as a submodule.

Parameters:
- WIDTH, 4, bit width of dividend, divisor, quotient and remainder (legal range 2..16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high; clears all state and outputs immediately.
- start  input  1  request pulse; sampled only in IDLE.
- dividend  input  WIDTH  numerator; sampled on the accepting edge only.
- divisor  input  WIDTH  denominator; sampled on the accepting edge only.
- busy  output  1  high while a division is in progress.
- done  output  1  single-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient; held until next accepted start.
- remainder  output  WIDTH  registered remainder; held until next accepted start.
- div_by_zero  output  1  set with done when divisor was 0; held with results.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal counter, shift and partial-remainder registers cleared.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: one-cycle result presentation; returns to IDLE on the next edge.
- Accept: edge E with state=IDLE and start=1.
  - Latch dividend into shift register Q, divisor into D.
  - Clear partial remainder R (WIDTH+1 bits).
  - Load step counter with WIDTH.
  - Clear div_by_zero.
  - busy=1 after E.
- Divisor==0 at accept:
  - Skip RUN and go to DONE at E.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - busy=0 after E.
- RUN step, each edge:
  - T = {R[WIDTH-1:0], Q[WIDTH-1]} − {1'b0, D}.
  - If T is non-negative (MSB 0): R=T and Q={Q[WIDTH-2:0],1}.
  - Otherwise: R={R[WIDTH-1:0],Q[WIDTH-1]} and Q={Q[WIDTH-2:0],0}.
  - Decrement the counter.
- Completion: on the edge where the counter reaches 0 (edge E+WIDTH):
  - quotient=Q, remainder=R[WIDTH-1:0].
  - state=DONE, busy=0.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Nonzero divisor: done is high in the cycle after edge E+WIDTH; busy is high for exactly WIDTH cycles.
  - Zero divisor: done is high in the cycle after E.
- start while busy (RUN) or in DONE: ignored; operands not resampled; no queueing.
- Back-to-back operation: start asserted during the DONE cycle is ignored. The earliest re-accept is the edge ending the first IDLE cycle.
- Operand changes after accept have no effect on the running operation.
- Outputs quotient, remainder and div_by_zero:
  - Change only at completion, at a zero-divisor accept, or at reset.
  - Stay stable between done pulses.
  - Are not cleared on a new accept, except div_by_zero, which is cleared at accept and then set/cleared at completion.
- Arithmetic: unsigned only. Result satisfies dividend = quotient*divisor + remainder, with remainder < divisor, for all divisor ≠ 0.
- Reset mid-RUN: operation abandoned. No done pulse; outputs zero; next start behaves as a fresh first operation.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=4, dividend=13, divisor=3, 1-cycle start → busy high exactly 4 cycles; done 1 cycle later; quotient=4, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 → quotient=15, remainder=0. Then dividend=5, divisor=7 → quotient=0, remainder=5. Outputs hold old values until each new completion.
- dividend=9, divisor=0 → done in the cycle after accept; busy never high; quotient=15, remainder=9, div_by_zero=1. A subsequent 6/2 → quotient=3, remainder=0, div_by_zero=0.
- Start 12/5, then pulse start with 14/7 and change operands during RUN → single done; quotient=2, remainder=2; second request ignored.
- Assert rst 2 cycles into a 15/2 run → busy, done and all outputs 0 immediately, no done pulse. After release, 15/2 → quotient=7, remainder=1.
- Exhaustive WIDTH=4 sweep, all 256 operand pairs, start held high continuously → each result matches the reference model; done spacing exactly WIDTH+2 cycles for nonzero divisors.

Source files
------------

// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// The requester drives the master side; the divider is the slave.
interface seq_divider_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider, one quotient bit per clock.
// A zero divisor short-circuits to DONE with quotient all ones and remainder = dividend.
module seq_divider #(
   parameter int WIDTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   seq_divider_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_d;
   // The partial remainder is always below the divisor, so its top bit
   // is identically zero and is not stored.
   logic [WIDTH-1:0] r_r;
   logic [CW-1:0]    r_cnt;

   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_dbz;

   logic             w_accept;
   logic             w_zero;
   logic             w_last;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_q_next;
   logic [WIDTH-1:0] w_r_next;
   logic             w_busy;
   logic             w_done;

   assign w_accept = (r_state == S_IDLE) && bus.start;
   assign w_zero   = (bus.divisor == '0);
   assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));
   assign w_shift  = {r_r, r_q[WIDTH-1]};
   assign w_trial  = w_shift - {1'b0, r_d};

   // One restoring step: keep the trial difference only when it did not borrow.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so
      // no path through it can leave a value unassigned and infer a latch.
      w_q_next = {r_q[WIDTH-2:0], 1'b0};
      w_r_next = w_shift[WIDTH-1:0];
      if (!w_trial[WIDTH]) begin
         w_q_next = {r_q[WIDTH-2:0], 1'b1};
         w_r_next = w_trial[WIDTH-1:0];
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_next = w_zero ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output decode; depends on the state register only.
   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      unique case (r_state)
         S_RUN:   w_busy = 1'b1;
         S_DONE:  w_done = 1'b1;
         default: ;
      endcase
   end

   // Datapath and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q         <= '0;
         r_d         <= '0;
         r_r         <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_dbz       <= 1'b0;
      end else if (w_accept) begin
         r_q   <= bus.dividend;
         r_d   <= bus.divisor;
         r_r   <= '0;
         r_cnt <= CW'(WIDTH);
         r_dbz <= w_zero;
         if (w_zero) begin
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
         end
      end else if (r_state == S_RUN) begin
         r_q   <= w_q_next;
         r_r   <= w_r_next;
         r_cnt <= r_cnt - CW'(1);
         if (w_last) begin
            r_quotient  <= w_q_next;
            r_remainder <= w_r_next;
            r_dbz       <= 1'b0;
         end
      end
   end

   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider at WIDTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seq_divider;

   localparam int W = 4;

   logic clk;
   logic rst;

   seq_divider_if #(.WIDTH(W)) bus ();

   seq_divider #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } vec_t;

   vec_t vecs[10];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // One start pulse; returns busy cycles, the cycle (1 = first after accept)
   // in which done was seen (-1 on timeout), and samples where results moved early.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cycles, output int done_cycle, output int hold_errs);
      logic [W-1:0] old_q;
      logic [W-1:0] old_r;
      int c;
      old_q = bus.quotient;
      old_r = bus.remainder;
      @(negedge clk);
      bus.dividend = a;
      bus.divisor  = b;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start   = 1'b0;
      busy_cycles = 0;
      hold_errs   = 0;
      c = 1;
      while (!bus.done && c <= 30) begin
         busy_cycles += int'(bus.busy);
         if (bus.quotient != old_q || bus.remainder != old_r) hold_errs++;
         @(negedge clk);
         c++;
      end
      done_cycle = bus.done ? c : -1;
   endtask

   initial begin
      int busy_c, done_c, hold_e, dones, gap;
      logic [W-1:0] cap_q, cap_r, eq, er;
      logic         edbz;
      bit           first;

      vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
      vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
      vecs[2] = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0};
      vecs[3] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1};
      vecs[4] = '{4'd6,  4'd2,  4'd3,  4'd0, 1'b0};
      vecs[5] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
      vecs[6] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
      vecs[7] = '{4'd14, 4'd4,  4'd3,  4'd2, 1'b0};
      vecs[8] = '{4'd8,  4'd0,  4'd15, 4'd8, 1'b1};
      vecs[9] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0};

      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (2) @(negedge clk);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset quotient", int'(bus.quotient), 0);
      check("reset remainder", int'(bus.remainder), 0);
      check("reset dbz", int'(bus.div_by_zero), 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_op(vecs[i].a, vecs[i].b, busy_c, done_c, hold_e);
         check($sformatf("vec%0d quotient", i), int'(bus.quotient), int'(vecs[i].q));
         check($sformatf("vec%0d remainder", i), int'(bus.remainder), int'(vecs[i].r));
         check($sformatf("vec%0d dbz", i), int'(bus.div_by_zero), int'(vecs[i].dbz));
         check($sformatf("vec%0d busy cycles", i), busy_c, vecs[i].b == 0 ? 0 : W);
         check($sformatf("vec%0d done cycle", i), done_c, vecs[i].b == 0 ? 1 : W + 1);
         check($sformatf("vec%0d hold", i), hold_e, 0);
         @(negedge clk);
         check($sformatf("vec%0d done pulse", i), int'(bus.done), 0);
      end

      // Second request during RUN plus operand churn must be ignored.
      @(negedge clk);
      bus.dividend = 4'd12;
      bus.divisor  = 4'd5;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      bus.dividend = 4'd14;
      bus.divisor  = 4'd7;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start    = 1'b0;
      bus.dividend = 4'd3;
      bus.divisor  = 4'd1;
      dones = 0;
      cap_q = '0;
      cap_r = '0;
      for (int c = 0; c < 20; c++) begin
         if (bus.done) begin
            dones++;
            cap_q = bus.quotient;
            cap_r = bus.remainder;
         end
         @(negedge clk);
      end
      check("ignore done count", dones, 1);
      check("ignore quotient", int'(cap_q), 2);
      check("ignore remainder", int'(cap_r), 2);

      // Reset two cycles into a 15/2 run.
      @(negedge clk);
      bus.dividend = 4'd15;
      bus.divisor  = 4'd2;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      check("midrun busy before rst", int'(bus.busy), 1);
      rst = 1'b1;
      #1;
      check("midrun rst busy", int'(bus.busy), 0);
      check("midrun rst done", int'(bus.done), 0);
      check("midrun rst quotient", int'(bus.quotient), 0);
      check("midrun rst remainder", int'(bus.remainder), 0);
      check("midrun rst dbz", int'(bus.div_by_zero), 0);
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         dones += int'(bus.done) + int'(bus.busy);
      end
      check("after rst no activity", dones, 0);
      do_op(4'd15, 4'd2, busy_c, done_c, hold_e);
      check("post rst quotient", int'(bus.quotient), 7);
      check("post rst remainder", int'(bus.remainder), 1);
      check("post rst done cycle", done_c, W + 1);

      // Exhaustive sweep with start held high; new operands applied in the DONE cycle.
      @(negedge clk);
      bus.start = 1'b1;
      first = 1'b1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            bus.dividend = 4'(a);
            bus.divisor  = 4'(b);
            gap = 0;
            do begin
               @(negedge clk);
               gap++;
            end while (!bus.done && gap < 20);
            if (b == 0) begin
               eq = 4'hF;
               er = 4'(a);
               edbz = 1'b1;
            end else begin
               eq = 4'(a / b);
               er = 4'(a % b);
               edbz = 1'b0;
            end
            check($sformatf("sweep %0d/%0d done", a, b), int'(bus.done), 1);
            check($sformatf("sweep %0d/%0d result", a, b),
                  int'({bus.quotient, bus.remainder, bus.div_by_zero}),
                  int'({eq, er, edbz}));
            if (!first) begin
               check($sformatf("sweep %0d/%0d spacing", a, b), gap, b == 0 ? 2 : W + 2);
            end
            first = 1'b0;
         end
      end
      bus.start = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
